// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: BadVAddr, Count, Compare, Status, Cause, EPC.
// Serves MFC0/MTC0 and records exception/ERET commits from the exception unit.
module cp0_regfile #(
  parameter int unsigned COUNT_DIV  = 2,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_exp,
  input  logic        clear_exl,
  input  logic [4:0]  exp_code,
  input  logic [31:0] epc,
  input  logic        in_delayslot,
  input  logic [31:0] badvaddr,
  input  logic        badvaddr_we,
  input  logic [5:0]  hw_int,
  input  logic        mtc0_we,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  input  logic [4:0]  cp0_raddr,
  output logic [31:0] cp0_rdata,
  output logic [31:0] epc_out,
  output logic        allow_int,
  output logic [7:0]  interrupt_flag,
  output logic        status_exl
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [1:0] DIV_LAST = 2'(COUNT_DIV - 1);

  logic [31:0] badvaddr_reg;
  logic [31:0] count_reg;
  logic [31:0] compare_reg;
  logic [31:0] epc_reg;
  logic [1:0]  div_cnt;

  logic [7:0]  im;
  logic        exl;
  logic        ie;

  logic        cause_bd;
  logic        cause_ti;
  logic [5:0]  cause_ip_hw;
  logic [1:0]  cause_ip_sw;
  logic [4:0]  cause_exc;

  logic        mtc0_eff;
  logic        count_wr;
  logic        compare_wr;
  logic        timer_match;
  logic [31:0] status_val;
  logic [31:0] cause_val;

  // Write qualification: an MTC0 alongside an exception or ERET belongs to a flushed instruction
  always_comb begin
    mtc0_eff    = mtc0_we & ~wr_exp & ~clear_exl;
    count_wr    = mtc0_eff & (cp0_waddr == REG_COUNT);
    compare_wr  = mtc0_eff & (cp0_waddr == REG_COMPARE);
    timer_match = (count_reg == compare_reg) & ~compare_wr;
  end

  // Count divider, Count register, timer interrupt and hardware IP sampling
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg   <= '0;
      div_cnt     <= '0;
      cause_ti    <= 1'b0;
      cause_ip_hw <= '0;
    end else begin
      if (count_wr) begin
        count_reg <= cp0_wdata;
        div_cnt   <= '0;
      end else if (div_cnt == DIV_LAST) begin
        div_cnt   <= '0;
        count_reg <= count_reg + 32'd1;
      end else begin
        div_cnt   <= div_cnt + 2'd1;
      end

      if (compare_wr) begin
        cause_ti <= 1'b0;
      end else if (timer_match) begin
        cause_ti <= 1'b1;
      end

      cause_ip_hw <= {hw_int[5] | cause_ti, hw_int[4:0]};
    end
  end

  // Exception commit, ERET commit and software-writable fields (priority: exception, ERET, MTC0)
  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr_reg <= '0;
      compare_reg  <= '0;
      epc_reg      <= '0;
      im           <= STATUS_RST[15:8];
      exl          <= STATUS_RST[1];
      ie           <= STATUS_RST[0];
      cause_bd     <= 1'b0;
      cause_ip_sw  <= '0;
      cause_exc    <= '0;
    end else if (wr_exp) begin
      if (!exl) begin
        epc_reg  <= epc;
        cause_bd <= in_delayslot;
      end
      exl       <= 1'b1;
      cause_exc <= exp_code;
      if (badvaddr_we) begin
        badvaddr_reg <= badvaddr;
      end
    end else if (clear_exl) begin
      exl <= 1'b0;
    end else if (mtc0_we) begin
      case (cp0_waddr)
        REG_COMPARE: compare_reg <= cp0_wdata;
        REG_STATUS: begin
          im  <= cp0_wdata[15:8];
          exl <= cp0_wdata[1];
          ie  <= cp0_wdata[0];
        end
        REG_CAUSE:   cause_ip_sw <= cp0_wdata[9:8];
        REG_EPC:     epc_reg     <= cp0_wdata;
        default: ;
      endcase
    end
  end

  // MFC0 read mux, pre-write values during a same-cycle MTC0
  always_comb begin
    status_val = {9'd0, 1'b1, 6'd0, im, 6'd0, exl, ie};
    cause_val  = {cause_bd, cause_ti, 14'd0, cause_ip_hw, cause_ip_sw, 1'b0, cause_exc, 2'b00};
    cp0_rdata  = '0;
    case (cp0_raddr)
      REG_BADVADDR: cp0_rdata = badvaddr_reg;
      REG_COUNT:    cp0_rdata = count_reg;
      REG_COMPARE:  cp0_rdata = compare_reg;
      REG_STATUS:   cp0_rdata = status_val;
      REG_CAUSE:    cp0_rdata = cause_val;
      REG_EPC:      cp0_rdata = epc_reg;
      default:      cp0_rdata = '0;
    endcase
  end

  // Feedback to the exception unit
  always_comb begin
    epc_out        = epc_reg;
    allow_int      = ie & ~exl;
    interrupt_flag = {cause_ip_hw, cause_ip_sw} & im;
    status_exl     = exl;
  end

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile with a register-level reference model.
module tb_cp0_regfile;

  localparam int unsigned CDIV = 2;
  localparam logic [31:0] SRST = 32'h0040_0000;

  logic        clk;
  logic        rst;
  logic        wr_exp;
  logic        clear_exl;
  logic [4:0]  exp_code;
  logic [31:0] epc;
  logic        in_delayslot;
  logic [31:0] badvaddr;
  logic        badvaddr_we;
  logic [5:0]  hw_int;
  logic        mtc0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [4:0]  cp0_raddr;
  logic [31:0] cp0_rdata;
  logic [31:0] epc_out;
  logic        allow_int;
  logic [7:0]  interrupt_flag;
  logic        status_exl;

  int checks = 0;
  int errors = 0;

  cp0_regfile #(.COUNT_DIV(CDIV), .STATUS_RST(SRST)) dut (
    .clk(clk), .rst(rst), .wr_exp(wr_exp), .clear_exl(clear_exl),
    .exp_code(exp_code), .epc(epc), .in_delayslot(in_delayslot),
    .badvaddr(badvaddr), .badvaddr_we(badvaddr_we), .hw_int(hw_int),
    .mtc0_we(mtc0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata), .epc_out(epc_out),
    .allow_int(allow_int), .interrupt_flag(interrupt_flag), .status_exl(status_exl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural register contents; Count is derived from
  // the value last loaded plus elapsed cycles divided by the prescaler.
  logic [31:0] m_badv, m_base, m_cmp, m_epc;
  int unsigned m_since;
  logic [7:0]  m_im;
  logic        m_exl, m_ie, m_bd, m_ti;
  logic [5:0]  m_iphw;
  logic [1:0]  m_ipsw;
  logic [4:0]  m_exc;

  function automatic logic [31:0] m_count();
    return m_base + 32'(m_since / CDIV);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [31:0] v;
    v = 32'd0;
    if (a == 5'd8)  v = m_badv;
    if (a == 5'd9)  v = m_count();
    if (a == 5'd11) v = m_cmp;
    if (a == 5'd12) v = 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
    if (a == 5'd13) v = (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_iphw) << 10)
                        | (32'(m_ipsw) << 8) | (32'(m_exc) << 2);
    if (a == 5'd14) v = m_epc;
    return v;
  endfunction

  function automatic logic m_allow();
    return m_ie && !m_exl;
  endfunction

  function automatic logic [7:0] m_flag();
    return {m_iphw, m_ipsw} & m_im;
  endfunction

  task automatic model_reset();
    m_badv = 0; m_base = 0; m_cmp = 0; m_epc = 0; m_since = 0;
    m_im = SRST[15:8]; m_exl = SRST[1]; m_ie = SRST[0];
    m_bd = 0; m_ti = 0; m_iphw = 0; m_ipsw = 0; m_exc = 0;
  endtask

  task automatic model_step();
    logic [31:0] c;
    logic mt, cmpw, match;
    if (rst) begin
      model_reset();
      return;
    end
    c     = m_count();
    mt    = mtc0_we && !wr_exp && !clear_exl;
    cmpw  = mt && (cp0_waddr == 5'd11);
    match = (c == m_cmp) && !cmpw;
    m_iphw = {hw_int[5] | m_ti, hw_int[4:0]};
    m_ti   = cmpw ? 1'b0 : (m_ti || match);
    if (mt && cp0_waddr == 5'd9) begin
      m_base = cp0_wdata; m_since = 0;
    end else begin
      m_since++;
    end
    if (wr_exp) begin
      if (!m_exl) begin m_epc = epc; m_bd = in_delayslot; end
      m_exl = 1; m_exc = exp_code;
      if (badvaddr_we) m_badv = badvaddr;
    end else if (clear_exl) begin
      m_exl = 0;
    end else if (mt) begin
      if (cp0_waddr == 5'd11) m_cmp = cp0_wdata;
      if (cp0_waddr == 5'd12) begin m_im = cp0_wdata[15:8]; m_exl = cp0_wdata[1]; m_ie = cp0_wdata[0]; end
      if (cp0_waddr == 5'd13) m_ipsw = cp0_wdata[9:8];
      if (cp0_waddr == 5'd14) m_epc = cp0_wdata;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    wr_exp = 0; clear_exl = 0; mtc0_we = 0; badvaddr_we = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0_we = 1; cp0_waddr = a; cp0_wdata = d;
    cyc();
    mtc0_we = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle(); hw_int = 0;
    cyc(); cyc();
    rst = 0;
    cp0_raddr = 5'd12; #1;
    checks++; if (cp0_rdata !== 32'h0040_0000) begin errors++; $display("FAIL reset_status: got %h expected %h", cp0_rdata, 32'h0040_0000); end
    checks++; if (allow_int !== 1'b0) begin errors++; $display("FAIL reset_allow_int: got %b expected 0", allow_int); end
    checks++; if (interrupt_flag !== 8'h00 || epc_out !== 32'd0 || status_exl !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got flag=%h epc=%h exl=%b expected 00/0/0", interrupt_flag, epc_out, status_exl); end
    for (int i = 0; i < 10; i++) cyc();
    cp0_raddr = 5'd9; #1;
    checks++; if (cp0_rdata !== 32'd5 || cp0_rdata !== m_read(5'd9)) begin
      errors++; $display("FAIL count_after_10: got %0d expected 5 (model %0d)", cp0_rdata, m_read(5'd9)); end
  endtask

  task automatic test_interrupt();
    mtc0(5'd11, 32'hFFFF_0000);
    mtc0(5'd12, 32'h0000_FF01);
    hw_int = 6'b000100;
    cyc();
    cp0_raddr = 5'd13; #1;
    checks++; if (cp0_rdata[12] !== 1'b1 || cp0_rdata !== m_read(5'd13)) begin
      errors++; $display("FAIL cause_ip4: got %h expected %h", cp0_rdata, m_read(5'd13)); end
    checks++; if (interrupt_flag !== 8'h10 || interrupt_flag !== m_flag()) begin
      errors++; $display("FAIL int_flag: got %h expected 10", interrupt_flag); end
    checks++; if (allow_int !== 1'b1) begin errors++; $display("FAIL allow_int_on: got %b expected 1", allow_int); end
    hw_int = 0;
  endtask

  task automatic test_exception();
    wr_exp = 1; exp_code = 5'd4; epc = 32'hBFC0_0100; in_delayslot = 1;
    badvaddr_we = 1; badvaddr = 32'h1235;
    cyc(); idle();
    checks++; if (epc_out !== 32'hBFC0_0100) begin errors++; $display("FAIL exc_epc: got %h expected bfc00100", epc_out); end
    cp0_raddr = 5'd13; #1;
    checks++; if (cp0_rdata[31] !== 1'b1 || cp0_rdata[6:2] !== 5'd4 || cp0_rdata !== m_read(5'd13)) begin
      errors++; $display("FAIL exc_cause: got %h expected %h", cp0_rdata, m_read(5'd13)); end
    cp0_raddr = 5'd8; #1;
    checks++; if (cp0_rdata !== 32'h1235) begin errors++; $display("FAIL exc_badvaddr: got %h expected 00001235", cp0_rdata); end
    checks++; if (status_exl !== 1'b1 || allow_int !== 1'b0) begin
      errors++; $display("FAIL exc_exl: got exl=%b allow=%b expected 1/0", status_exl, allow_int); end
    // Nested exception with EXL set
    wr_exp = 1; exp_code = 5'd5; epc = 32'h8000_0000; in_delayslot = 0;
    cyc(); idle();
    cp0_raddr = 5'd13; #1;
    checks++; if (epc_out !== 32'hBFC0_0100) begin errors++; $display("FAIL nested_epc: got %h expected bfc00100", epc_out); end
    checks++; if (cp0_rdata[6:2] !== 5'd5 || cp0_rdata[31] !== 1'b1) begin
      errors++; $display("FAIL nested_cause: got %h expected exc=5 bd=1", cp0_rdata); end
    clear_exl = 1;
    cyc(); idle();
    checks++; if (status_exl !== 1'b0 || allow_int !== 1'b1) begin
      errors++; $display("FAIL eret_exl: got exl=%b allow=%b expected 0/1", status_exl, allow_int); end
  endtask

  task automatic test_timer();
    logic found;
    mtc0(5'd9, 32'd0);
    mtc0(5'd11, 32'd3);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      cp0_raddr = 5'd13; #1;
      if (cp0_rdata[30] === 1'b1) begin found = 1; break; end
    end
    checks++; if (found !== 1'b1 || m_ti !== 1'b1) begin errors++; $display("FAIL timer_set: got %b expected 1 within 20 cycles", found); end
    cp0_raddr = 5'd9; #1;
    checks++; if (cp0_rdata !== 32'd3 || cp0_rdata !== m_read(5'd9)) begin
      errors++; $display("FAIL timer_count: got %0d expected 3", cp0_rdata); end
    cyc();
    cp0_raddr = 5'd13; #1;
    checks++; if (cp0_rdata[15] !== 1'b1 || interrupt_flag[7] !== 1'b1) begin
      errors++; $display("FAIL timer_ip7: got cause=%h flag=%h expected ip7 set", cp0_rdata, interrupt_flag); end
    mtc0(5'd11, 32'd100);
    cp0_raddr = 5'd13; #1;
    checks++; if (cp0_rdata[30] !== 1'b0 || cp0_rdata !== m_read(5'd13)) begin
      errors++; $display("FAIL timer_clear: got %h expected %h", cp0_rdata, m_read(5'd13)); end
  endtask

  task automatic test_flush_and_wrap();
    mtc0_we = 1; cp0_waddr = 5'd14; cp0_wdata = 32'hDEAD_BEEF;
    wr_exp = 1; exp_code = 5'd8; epc = 32'h1111_0000; in_delayslot = 0;
    cyc(); idle();
    checks++; if (epc_out !== 32'h1111_0000) begin errors++; $display("FAIL flush_epc: got %h expected 11110000", epc_out); end
    clear_exl = 1; cyc(); idle();
    mtc0(5'd9, 32'hFFFF_FFFF);
    cp0_raddr = 5'd9; #1;
    checks++; if (cp0_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL count_load: got %h expected ffffffff", cp0_rdata); end
    for (int i = 0; i < int'(CDIV); i++) cyc();
    checks++; if (cp0_rdata !== 32'd0 || cp0_rdata !== m_read(5'd9)) begin
      errors++; $display("FAIL count_wrap: got %h expected 00000000", cp0_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] old;
    cp0_raddr = 5'd11; #1;
    old = m_read(5'd11);
    mtc0_we = 1; cp0_waddr = 5'd11; cp0_wdata = 32'h55; #1;
    checks++; if (cp0_rdata !== old) begin errors++; $display("FAIL rdw_old: got %h expected %h", cp0_rdata, old); end
    cyc(); mtc0_we = 0; #1;
    checks++; if (cp0_rdata !== 32'h55) begin errors++; $display("FAIL rdw_new: got %h expected 00000055", cp0_rdata); end
    mtc0(5'd20, 32'hFFFF_FFFF);
    cp0_raddr = 5'd20; #1;
    checks++; if (cp0_rdata !== 32'd0) begin errors++; $display("FAIL unmapped: got %h expected 0", cp0_rdata); end
    wr_exp = 1; clear_exl = 1; exp_code = 5'd12; epc = 32'h2222_0000;
    cyc(); idle();
    checks++; if (status_exl !== 1'b1 || epc_out !== 32'h2222_0000) begin
      errors++; $display("FAIL exp_beats_eret: got exl=%b epc=%h expected 1/22220000", status_exl, epc_out); end
    rst = 1; wr_exp = 1; mtc0_we = 1; cp0_waddr = 5'd14; cp0_wdata = 32'h1;
    cyc(); rst = 0; idle();
    cp0_raddr = 5'd12; #1;
    checks++; if (cp0_rdata !== 32'h0040_0000 || epc_out !== 32'd0 || status_exl !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got status=%h epc=%h exl=%b expected 00400000/0/0", cp0_rdata, epc_out, status_exl); end
  endtask

  task automatic test_random();
    logic [4:0] addrs [8];
    addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd31};
    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(0, 99) == 0);
      wr_exp       = ($urandom_range(0, 9) == 0);
      clear_exl    = ($urandom_range(0, 9) == 0);
      mtc0_we      = ($urandom_range(0, 2) == 0);
      cp0_waddr    = addrs[$urandom_range(0, 7)];
      cp0_wdata    = $urandom;
      if (cp0_waddr == 5'd11 && $urandom_range(0, 1) == 0) cp0_wdata = m_count() + 32'($urandom_range(0, 3));
      exp_code     = 5'($urandom);
      epc          = $urandom;
      in_delayslot = 1'($urandom);
      badvaddr     = $urandom;
      badvaddr_we  = 1'($urandom);
      if ($urandom_range(0, 3) == 0) hw_int = 6'($urandom);
      cyc();
      rst = 0; idle();
      cp0_raddr = addrs[$urandom_range(0, 7)]; #1;
      checks++; if (cp0_rdata !== m_read(cp0_raddr)) begin
        errors++; $display("FAIL rand_rdata[%0d] addr %0d: got %h expected %h", n, cp0_raddr, cp0_rdata, m_read(cp0_raddr)); end
      checks++; if (epc_out !== m_epc) begin errors++; $display("FAIL rand_epc[%0d]: got %h expected %h", n, epc_out, m_epc); end
      checks++; if (allow_int !== m_allow()) begin errors++; $display("FAIL rand_allow[%0d]: got %b expected %b", n, allow_int, m_allow()); end
      checks++; if (interrupt_flag !== m_flag()) begin errors++; $display("FAIL rand_flag[%0d]: got %h expected %h", n, interrupt_flag, m_flag()); end
      checks++; if (status_exl !== m_exl) begin errors++; $display("FAIL rand_exl[%0d]: got %b expected %b", n, status_exl, m_exl); end
    end
  endtask

  initial begin
    rst = 1; wr_exp = 0; clear_exl = 0; exp_code = 0; epc = 0; in_delayslot = 0;
    badvaddr = 0; badvaddr_we = 0; hw_int = 0; mtc0_we = 0; cp0_waddr = 0;
    cp0_wdata = 0; cp0_raddr = 0;
    model_reset();
    test_reset();
    test_interrupt();
    test_exception();
    test_timer();
    test_flush_and_wrap();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
